// File: rtl/mmio_pkg.sv
// Shared register offsets and the hex-to-segment map for the on-board I/O block.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package mmio_pkg;

    localparam logic [5:0] OFF_LED       = 6'h00;
    localparam logic [5:0] OFF_SW        = 6'h10;
    localparam logic [5:0] OFF_BTN_LVL   = 6'h20;
    localparam logic [5:0] OFF_BTN_PRESS = 6'h24;
    localparam logic [5:0] OFF_IRQ_MASK  = 6'h28;
    localparam logic [5:0] OFF_TUBE_VAL  = 6'h30;
    localparam logic [5:0] OFF_TUBE_MASK = 6'h34;
    localparam logic [5:0] OFF_TUBE_DP   = 6'h38;

    function automatic logic [6:0] hex7seg(input logic [3:0] nib);
        logic [6:0] lit;
        case (nib)
            4'h0: lit = 7'h3F;
            4'h1: lit = 7'h06;
            4'h2: lit = 7'h5B;
            4'h3: lit = 7'h4F;
            4'h4: lit = 7'h66;
            4'h5: lit = 7'h6D;
            4'h6: lit = 7'h7D;
            4'h7: lit = 7'h07;
            4'h8: lit = 7'h7F;
            4'h9: lit = 7'h6F;
            4'hA: lit = 7'h77;
            4'hB: lit = 7'h7C;
            4'hC: lit = 7'h39;
            4'hD: lit = 7'h5E;
            4'hE: lit = 7'h79;
            default: lit = 7'h71;
        endcase
        return ~lit;
    endfunction

endpackage

// File: rtl/mmio_debounce.sv
// One-button debouncer: 2-FF synchroniser, stability counter and accepted level.
// rise_o pulses in the same cycle the level register turns 0 -> 1.
module mmio_debounce #(
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic cpu_clk,
    input  logic rst,
    input  logic btn_i,
    output logic level_o,
    output logic rise_o
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic [CW-1:0] cnt_q;
    logic          flip;

    // The DEBOUNCE_CYCLES-th consecutive disagreeing sample accepts the new level.
    assign flip = (sync2_q != level_q) && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge cpu_clk) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            if ((sync2_q == level_q) || flip) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (flip) begin
                level_q <= ~level_q;
            end
        end
    end

    assign level_o = level_q;
    assign rise_o  = flip & ~level_q;

endmodule

// File: rtl/mmio_io_ctrl.sv
// MMIO slave for LEDs, switches, debounced buttons and a scanned 7-segment display.
// Optional button interrupt (irq port, IRQ_MASK register) is built when MMIO_BTN_IRQ_EN is defined.
module mmio_io_ctrl
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR       = 32'h10000C60,
    parameter int          LED_W           = 24,
    parameter int          SW_W            = 24,
    parameter int          BTN_N           = 5,
    parameter int          TUBE_DIGITS     = 8,
    parameter int          REFRESH_DIV     = 100000,
    parameter int          DEBOUNCE_CYCLES = 20000
) (
    input  logic             cpu_clk,
    input  logic             rst,
    input  logic [31:0]      addr,
    input  logic [31:0]      write_data,
    input  logic             wea,
    input  logic             mode,
    output logic [31:0]      read_data,
    input  logic [BTN_N-1:0] buttons,
    input  logic [SW_W-1:0]  switches,
    output logic [LED_W-1:0] led,
    output logic [7:0]       tube_en,
    output logic [7:0]       tube_seg
`ifdef MMIO_BTN_IRQ_EN
    ,
    output logic             irq
`endif
);
    localparam int DIV_W = $clog2(REFRESH_DIV);

    logic [31:0]      off;
    logic             hit;
    logic             wr;
    logic [31:0]      rd_d;
    logic [31:0]      read_data_q;
    logic [LED_W-1:0] led_q;
    logic [SW_W-1:0]  sw1_q;
    logic [SW_W-1:0]  sw2_q;
    logic [31:0]      tube_val_q;
    logic [7:0]       tube_mask_q;
    logic [7:0]       tube_dp_q;
    logic [BTN_N-1:0] btn_lvl;
    logic [BTN_N-1:0] btn_rise;
    logic [BTN_N-1:0] press_q;
    logic [BTN_N-1:0] press_d;
    logic [DIV_W-1:0] div_q;
    logic [2:0]       idx_q;
    logic [3:0]       nib;
    logic [7:0]       seg_d;
    logic [7:0]       tube_en_q;
    logic [7:0]       tube_seg_q;
`ifdef MMIO_BTN_IRQ_EN
    logic [BTN_N-1:0] irq_mask_q;
    logic             irq_q;
`endif

    assign off = addr - BASE_ADDR;
    assign hit = (off < 32'h40) && (addr[1:0] == 2'b00);
    assign wr  = wea & mode & hit;

    for (genvar b = 0; b < BTN_N; b++) begin : g_btn
        mmio_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .cpu_clk (cpu_clk),
            .rst     (rst),
            .btn_i   (buttons[b]),
            .level_o (btn_lvl[b]),
            .rise_o  (btn_rise[b])
        );
    end

    always_comb begin
        rd_d = '0;
        if (hit) begin
            case (off[5:0])
                OFF_LED:       rd_d[LED_W-1:0] = led_q;
                OFF_SW:        rd_d[SW_W-1:0]  = sw2_q;
                OFF_BTN_LVL:   rd_d[BTN_N-1:0] = btn_lvl;
                OFF_BTN_PRESS: rd_d[BTN_N-1:0] = press_q;
`ifdef MMIO_BTN_IRQ_EN
                OFF_IRQ_MASK:  rd_d[BTN_N-1:0] = irq_mask_q;
`endif
                OFF_TUBE_VAL:  rd_d            = tube_val_q;
                OFF_TUBE_MASK: rd_d[7:0]       = tube_mask_q;
                OFF_TUBE_DP:   rd_d[7:0]       = tube_dp_q;
                default:       rd_d            = '0;
            endcase
        end
    end

    // A new rise wins over a W1C landing in the same cycle.
    always_comb begin
        press_d = press_q;
        if (wr && (off[5:0] == OFF_BTN_PRESS)) begin
            press_d = press_q & ~write_data[BTN_N-1:0];
        end
        press_d = press_d | btn_rise;
    end

    always_ff @(posedge cpu_clk) begin
        if (!rst) begin
            read_data_q <= '0;
            led_q       <= '0;
            sw1_q       <= '0;
            sw2_q       <= '0;
            tube_val_q  <= '0;
            tube_mask_q <= '0;
            tube_dp_q   <= '0;
            press_q     <= '0;
`ifdef MMIO_BTN_IRQ_EN
            irq_mask_q  <= '0;
            irq_q       <= 1'b0;
`endif
        end else begin
            read_data_q <= rd_d;
            sw1_q       <= switches;
            sw2_q       <= sw1_q;
            press_q     <= press_d;
`ifdef MMIO_BTN_IRQ_EN
            irq_q       <= |(press_q & irq_mask_q);
`endif
            if (wr) begin
                case (off[5:0])
                    OFF_LED:       led_q       <= write_data[LED_W-1:0];
`ifdef MMIO_BTN_IRQ_EN
                    OFF_IRQ_MASK:  irq_mask_q  <= write_data[BTN_N-1:0];
`endif
                    OFF_TUBE_VAL:  tube_val_q  <= write_data;
                    OFF_TUBE_MASK: tube_mask_q <= write_data[7:0];
                    OFF_TUBE_DP:   tube_dp_q   <= write_data[7:0];
                    default:       ;
                endcase
            end
        end
    end

    assign nib   = tube_val_q[{idx_q, 2'b00} +: 4];
    assign seg_d = tube_mask_q[idx_q] ? 8'hFF : {~tube_dp_q[idx_q], hex7seg(nib)};

    // Outputs are loaded only at slot start so a register write never glitches a lit digit.
    always_ff @(posedge cpu_clk) begin
        if (!rst) begin
            div_q      <= '0;
            idx_q      <= '0;
            tube_en_q  <= 8'hFF;
            tube_seg_q <= 8'hFF;
        end else begin
            if (div_q == '0) begin
                tube_en_q  <= ~(8'h01 << idx_q);
                tube_seg_q <= seg_d;
            end
            if (div_q == DIV_W'(REFRESH_DIV - 1)) begin
                div_q <= '0;
                idx_q <= (idx_q == 3'(TUBE_DIGITS - 1)) ? 3'd0 : idx_q + 3'd1;
            end else begin
                div_q <= div_q + 1'b1;
            end
        end
    end

    assign read_data = read_data_q;
    assign led       = led_q;
    assign tube_en   = tube_en_q;
    assign tube_seg  = tube_seg_q;
`ifdef MMIO_BTN_IRQ_EN
    assign irq       = irq_q;
`endif

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// Bench for mmio_io_ctrl: spec-level model compared every cycle plus directed literal checks.
module tb_mmio_io_ctrl;
    localparam logic [31:0] BASE = 32'h10000C60;
    localparam int RD = 4;
    localparam int DC = 4;
    localparam int TD = 8;

    logic        cpu_clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic        wea;
    logic        mode;
    logic [31:0] read_data;
    logic [4:0]  buttons;
    logic [23:0] switches;
    logic [23:0] led;
    logic [7:0]  tube_en;
    logic [7:0]  tube_seg;
`ifdef MMIO_BTN_IRQ_EN
    logic        irq;
`endif

    always #5 cpu_clk = ~cpu_clk;

    mmio_io_ctrl #(
        .BASE_ADDR(BASE), .LED_W(24), .SW_W(24), .BTN_N(5), .TUBE_DIGITS(TD),
        .REFRESH_DIV(RD), .DEBOUNCE_CYCLES(DC)
    ) dut (
        .cpu_clk(cpu_clk), .rst(rst), .addr(addr), .write_data(write_data),
        .wea(wea), .mode(mode), .read_data(read_data), .buttons(buttons),
        .switches(switches), .led(led), .tube_en(tube_en), .tube_seg(tube_seg)
`ifdef MMIO_BTN_IRQ_EN
        , .irq(irq)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    logic [23:0] m_led, m_sw1, m_sw2;
    logic [31:0] m_val, m_rd;
    logic [7:0]  m_mask, m_dp, m_en, m_seg;
    logic [4:0]  m_press, m_irqmask, m_lvl, m_b1, m_b2, m_rise, m_w1c;
    logic        m_irq, m_irq_n;
    int          m_run[5];
    int          m_k;

    function automatic logic [6:0] seg_on(input logic [3:0] n);
        logic [6:0] t [16];
        t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        return t[n];
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [31:0] o;
        o = a - BASE;
        if (o >= 32'h40 || a[1:0] != 2'b00) return 32'h0;
        case (o[5:0])
            6'h00: return {8'h0, m_led};
            6'h10: return {8'h0, m_sw2};
            6'h20: return {27'h0, m_lvl};
            6'h24: return {27'h0, m_press};
`ifdef MMIO_BTN_IRQ_EN
            6'h28: return {27'h0, m_irqmask};
`endif
            6'h30: return m_val;
            6'h34: return {24'h0, m_mask};
            6'h38: return {24'h0, m_dp};
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge cpu_clk) begin
        if (!rst) begin
            m_led = 0; m_sw1 = 0; m_sw2 = 0; m_val = 0; m_rd = 0; m_mask = 0; m_dp = 0;
            m_en = 8'hFF; m_seg = 8'hFF; m_press = 0; m_irqmask = 0; m_lvl = 0;
            m_b1 = 0; m_b2 = 0; m_irq = 0; m_k = 0;
            for (int b = 0; b < 5; b++) m_run[b] = 0;
        end else begin
            m_irq_n = |(m_press & m_irqmask);
            m_rd = m_read(addr);
            if (m_k % RD == 0) begin
                int i;
                i = (m_k / RD) % TD;
                m_en  = ~(8'h01 << i);
                m_seg = m_mask[i] ? 8'hFF : {~m_dp[i], ~seg_on(m_val[i*4 +: 4])};
            end
            m_k++;
            m_rise = 0;
            for (int b = 0; b < 5; b++) begin
                if (m_b2[b] != m_lvl[b]) begin
                    m_run[b]++;
                    if (m_run[b] == DC) begin
                        m_lvl[b]  = ~m_lvl[b];
                        m_rise[b] = m_lvl[b];
                        m_run[b]  = 0;
                    end
                end else begin
                    m_run[b] = 0;
                end
            end
            m_w1c = 0;
            if (wea && mode && ((addr - BASE) < 32'h40) && addr[1:0] == 2'b00) begin
                case (6'(addr - BASE))
                    6'h00: m_led = write_data[23:0];
                    6'h24: m_w1c = write_data[4:0];
`ifdef MMIO_BTN_IRQ_EN
                    6'h28: m_irqmask = write_data[4:0];
`endif
                    6'h30: m_val  = write_data;
                    6'h34: m_mask = write_data[7:0];
                    6'h38: m_dp   = write_data[7:0];
                    default: ;
                endcase
            end
            m_press = (m_press & ~m_w1c) | m_rise;
            m_b2 = m_b1; m_b1 = buttons;
            m_sw2 = m_sw1; m_sw1 = switches;
            m_irq = m_irq_n;
        end
    end

    always @(negedge cpu_clk) begin
        if (chk_en) begin
            check("cyc_led", {8'h0, led}, {8'h0, m_led});
            check("cyc_read_data", read_data, m_rd);
            check("cyc_tube_en", {24'h0, tube_en}, {24'h0, m_en});
            check("cyc_tube_seg", {24'h0, tube_seg}, {24'h0, m_seg});
`ifdef MMIO_BTN_IRQ_EN
            check("cyc_irq", {31'h0, irq}, {31'h0, m_irq});
`endif
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge cpu_clk);
            @(negedge cpu_clk);
        end
    endtask

    task automatic wr(input logic [5:0] o, input logic [31:0] d);
        addr = BASE + {26'h0, o}; write_data = d; wea = 1'b1; mode = 1'b1;
        tick();
        wea = 1'b0;
    endtask

    task automatic rd_check(input string nm, input logic [5:0] o, input logic [31:0] exp);
        addr = BASE + {26'h0, o};
        tick();
        check(nm, read_data, exp);
    endtask

    task automatic wait_en(input logic [7:0] v, input bit want_eq);
        int n;
        n = 0;
        while (((tube_en == v) != want_eq) && n < 100) begin
            tick();
            n++;
        end
        check("tube_wait", {31'h0, n < 100}, 32'h1);
    endtask

    initial begin
        rst = 1'b0; addr = BASE; write_data = 0; wea = 0; mode = 0;
        buttons = 0; switches = 0;
        @(negedge cpu_clk);
        tick();
        chk_en = 1'b1;
        tick();
        check("rst_led", {8'h0, led}, 32'h0);
        check("rst_tube_en", {24'h0, tube_en}, 32'hFF);
        check("rst_tube_seg", {24'h0, tube_seg}, 32'hFF);
        check("rst_read_data", read_data, 32'h0);
        rst = 1'b1;

        // LED write, mode gating and read latency
        addr = BASE; write_data = 32'h00A5A5A5; wea = 1; mode = 0;
        tick();
        wea = 0;
        check("led_mode0", {8'h0, led}, 32'h0);
        mode = 1; wea = 1;
        tick();
        wea = 0;
        check("led_write", {8'h0, led}, 32'h00A5A5A5);
        check("led_same_cycle_read_old", read_data, 32'h0);
        tick();
        check("led_read", read_data, 32'h00A5A5A5);

        // switches and unmapped offset
        switches = 24'h123456;
        addr = BASE + 32'h10;
        tick(3);
        check("sw_read", read_data, 32'h00123456);
        rd_check("unmapped_3c", 6'h3C, 32'h0);

        // debounce: short glitch, real press, W1C, W1C racing a new rise
        buttons = 5'b00001;
        tick(3);
        buttons = 5'b00000;
        tick(8);
        rd_check("btn_glitch_lvl", 6'h20, 32'h0);
        buttons = 5'b00001;
        tick(8);
        rd_check("btn_lvl_high", 6'h20, 32'h1);
        rd_check("btn_press_set", 6'h24, 32'h1);
        wr(6'h24, 32'h1);
        rd_check("btn_press_w1c", 6'h24, 32'h0);
        buttons = 5'b00000;
        tick(10);
        rd_check("btn_lvl_low", 6'h20, 32'h0);
        buttons = 5'b00001;
        tick(5);
        wr(6'h24, 32'h1);
        rd_check("btn_w1c_race_set_wins", 6'h24, 32'h1);
        buttons = 5'b00000;
        wr(6'h24, 32'h1F);
        tick(10);

        // tube scan
        wr(6'h30, 32'h76543210);
        wr(6'h34, 32'h02);
        wr(6'h38, 32'h00);
        addr = BASE;
        wait_en(8'hFE, 1'b0);
        wait_en(8'hFE, 1'b1);
        check("tube_d0_en", {24'h0, tube_en}, 32'hFE);
        check("tube_d0_seg", {24'h0, tube_seg}, 32'hC0);
        tick(4);
        check("tube_d1_en", {24'h0, tube_en}, 32'hFD);
        check("tube_d1_seg_masked", {24'h0, tube_seg}, 32'hFF);
        tick(4);
        check("tube_d2_en", {24'h0, tube_en}, 32'hFB);
        check("tube_d2_seg", {24'h0, tube_seg}, 32'hA4);
        wr(6'h38, 32'h08);
        tick(3);
        check("tube_d3_en", {24'h0, tube_en}, 32'hF7);
        check("tube_d3_seg_dp", {24'h0, tube_seg}, 32'h30);

        // reset mid-scan with a concurrent write
        wr(6'h00, 32'h00FFFFFF);
        tick(2);
        rst = 0; addr = BASE; write_data = 32'h00123456; wea = 1; mode = 1;
        tick();
        check("rst2_led", {8'h0, led}, 32'h0);
        check("rst2_tube_en", {24'h0, tube_en}, 32'hFF);
        check("rst2_read_data", read_data, 32'h0);
        rst = 1; wea = 0;
        tick();
        check("rst2_write_dropped", {8'h0, led}, 32'h0);

`ifdef MMIO_BTN_IRQ_EN
        wr(6'h28, 32'h01);
        buttons = 5'b00001;
        tick(8);
        check("irq_set", {31'h0, irq}, 32'h1);
        wr(6'h24, 32'h01);
        tick();
        check("irq_clear", {31'h0, irq}, 32'h0);
        buttons = 5'b00000;
        tick(10);
        buttons = 5'b00010;
        tick(10);
        check("irq_masked_btn1", {31'h0, irq}, 32'h0);
        rd_check("irq_btn1_press", 6'h24, 32'h2);
`else
        wr(6'h28, 32'h1F);
        rd_check("irqmask_absent", 6'h28, 32'h0);
`endif

        tick(2);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
